// File: rtl/bram_ctrl.sv
// Single-port block-RAM controller: request/wait handshake, byte-lane writes,
// programmable wait states, out-of-range flagging. Optional parity: BRAM_PARITY_EN.
module bram_ctrl #(
  parameter int DATA_W      = 16,
  parameter int BYTE_W      = 8,
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          d,
  input  logic [DATA_W/BYTE_W-1:0]   be,
  input  logic                       rd,
  input  logic                       wr,
  output logic [DATA_W-1:0]          q,
  output logic                       mwait,
  output logic                       done,
  output logic                       err,
  output logic                       perr
);

  localparam int NL = DATA_W / BYTE_W;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam bit NO_WAIT = (WAIT_STATES == 0);
  localparam logic [2:0] WS_INIT = 3'(WAIT_STATES - 1);

  // Handshake: a request (rd or wr held high) is accepted on any rising edge
  // where mwait is low; mwait then stays high until the cycle carrying done.
  typedef enum logic [1:0] {IDLE, ACCESS, DELAY} state_t;

  state_t            state, state_nx;
  logic [2:0]        wcnt, wcnt_nx;
  logic [ADDR_W-1:0] a_lat;
  logic [DATA_W-1:0] d_lat;
  logic [NL-1:0]     be_lat;
  logic              is_rd;
  logic              last;
  logic              in_range;
  logic [IW-1:0]     idx;

  logic [DATA_W-1:0] m [DEPTH];

  assign in_range = ({1'b0, a_lat} < DEPTH_C);
  assign idx      = a_lat[IW-1:0];

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    last     = 1'b0;
    case (state)
      IDLE:   if (rd || wr) state_nx = ACCESS;
      ACCESS: begin
        if (NO_WAIT) begin
          last     = 1'b1;
          state_nx = IDLE;
        end else begin
          wcnt_nx  = WS_INIT;
          state_nx = DELAY;
        end
      end
      DELAY: begin
        if (wcnt == 3'd0) begin
          last     = 1'b1;
          state_nx = IDLE;
        end else begin
          wcnt_nx = wcnt - 3'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      wcnt  <= 3'd0;
      q     <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      if (state == ACCESS && is_rd) q <= in_range ? m[idx] : '0;
    end
  end

  // Transaction latches; rd wins over wr when both are raised.
  always_ff @(posedge clock) begin
    if (state == IDLE && (rd || wr)) begin
      a_lat  <= addr;
      d_lat  <= d;
      be_lat <= be;
      is_rd  <= rd;
    end
  end

  // RAM contents survive reset, but a write colliding with reset is dropped.
  always_ff @(posedge clock) begin
    if (reset && state == ACCESS && !is_rd && in_range) begin
      for (int i = 0; i < NL; i++)
        if (be_lat[i]) m[idx][i*BYTE_W +: BYTE_W] <= d_lat[i*BYTE_W +: BYTE_W];
    end
  end

  // done/err are decoded from state, so reset clears them with the FSM.
  assign mwait = (state != IDLE);
  assign done  = last;
  assign err   = last & ~in_range;

`ifdef BRAM_PARITY_EN
  logic [NL-1:0] par [DEPTH];
  logic [NL-1:0] par_calc;
  logic          par_bad;
  logic          perr_lat;

  always_comb begin
    par_calc = '0;
    for (int i = 0; i < NL; i++) par_calc[i] = ^m[idx][i*BYTE_W +: BYTE_W];
  end

  assign par_bad = is_rd & in_range & (par_calc != par[idx]);

  always_ff @(posedge clock) begin
    if (reset && state == ACCESS && !is_rd && in_range) begin
      for (int i = 0; i < NL; i++)
        if (be_lat[i]) par[idx][i] <= ^d_lat[i*BYTE_W +: BYTE_W];
    end
  end

  // Parity is evaluated in ACCESS and held until the done cycle.
  always_ff @(posedge clock) begin
    if (!reset)                perr_lat <= 1'b0;
    else if (state == ACCESS)  perr_lat <= par_bad;
  end

  assign perr = last & ((state == ACCESS) ? par_bad : perr_lat);
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_bram_ctrl.sv
// Bench for bram_ctrl: transaction-level reference model, per-cycle compare,
// directed literal checks and randomized traffic.
module tb_bram_ctrl;
  localparam int DATA_W = 16;
  localparam int BYTE_W = 8;
  localparam int NL     = 2;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 768;
  localparam int WS     = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [ADDR_W-1:0] addr  = '0;
  logic [DATA_W-1:0] d     = '0;
  logic [NL-1:0]     be    = '0;
  logic              rd    = 1'b0;
  logic              wr    = 1'b0;
  logic [DATA_W-1:0] q;
  logic              mwait, done, err, perr;

  bram_ctrl #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W),
              .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clock(clock), .reset(reset), .addr(addr), .d(d), .be(be),
    .rd(rd), .wr(wr), .q(q), .mwait(mwait), .done(done), .err(err), .perr(perr)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] mm    [DEPTH];
  logic [NL-1:0]     known [DEPTH];
  logic [NL-1:0]     mpar  [DEPTH];
  int                rem = 0;
  bit                t_rd;
  logic [ADDR_W-1:0] t_addr;
  logic [DATA_W-1:0] t_d;
  logic [NL-1:0]     t_be;
  bit                t_pbad, t_pknown;
  logic [DATA_W-1:0] exp_q = '0;
  bit                q_known = 1;

  initial for (int i = 0; i < DEPTH; i++) known[i] = '0;

  function automatic logic [NL-1:0] lane_par(input logic [DATA_W-1:0] w);
    logic [NL-1:0] p;
    for (int i = 0; i < NL; i++) p[i] = ^w[i*BYTE_W +: BYTE_W];
    return p;
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      rem = 0; exp_q = '0; q_known = 1;
    end else if (rem == 0) begin
      if (rd || wr) begin
        rem = WS + 1; t_rd = rd; t_addr = addr; t_d = d; t_be = be;
        t_pbad = 0; t_pknown = 1;
        if (rd && addr < DEPTH) begin
          t_pknown = (known[addr] == '1);
          if (t_pknown) t_pbad = (lane_par(mm[addr]) != mpar[addr]);
        end
      end
    end else begin
      if (rem == WS + 1) begin
        if (t_rd) begin
          if (t_addr < DEPTH) begin exp_q = mm[t_addr]; q_known = (known[t_addr] == '1); end
          else begin exp_q = '0; q_known = 1; end
        end else if (t_addr < DEPTH) begin
          for (int i = 0; i < NL; i++) if (t_be[i]) begin
            mm[t_addr][i*BYTE_W +: BYTE_W] = t_d[i*BYTE_W +: BYTE_W];
            mpar[t_addr][i] = ^t_d[i*BYTE_W +: BYTE_W];
            known[t_addr][i] = 1'b1;
          end
        end
      end
      rem--;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (chk_en) begin
      chk("mwait", 32'(mwait), 32'(rem != 0));
      chk("done",  32'(done),  32'(rem == 1));
      chk("err",   32'(err),   32'(rem == 1 && t_addr >= DEPTH));
      if (q_known) chk("q", 32'(q), 32'(exp_q));
`ifdef BRAM_PARITY_EN
      if (t_pknown) chk("perr", 32'(perr), 32'(rem == 1 && t_pbad));
`else
      chk("perr", 32'(perr), 32'd0);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while (mwait && n < 50) begin @(negedge clock); n++; end
    if (n >= 50) chk("idle_timeout", 32'(mwait), 32'd0);
  endtask

  task automatic req(input bit r, input bit w, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] dd, input logic [NL-1:0] bb,
                     output int busy, output logic [DATA_W-1:0] q_first,
                     output bit err_seen, output bit perr_seen);
    wait_idle();
    rd = r; wr = w; addr = a; d = dd; be = bb;
    @(negedge clock);
    rd = 0; wr = 0;
    busy = 0; q_first = q; err_seen = 0; perr_seen = 0;
    while (mwait && busy < 20) begin
      busy++;
      if (done) begin err_seen = err; perr_seen = perr; end
      @(negedge clock);
    end
  endtask

  int busy;
  logic [DATA_W-1:0] qf;
  bit es, ps;

  initial begin
    @(negedge clock);
    chk_en = 1;
    @(negedge clock);
    reset = 1;
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_mwait", 32'(mwait), 32'h0);

    // first read after reset: q holds 0 through ACCESS, mwait high WS+1 cycles
    req(1, 0, 10'h005, 16'h0, 2'b00, busy, qf, es, ps);
    chk("rd005_busy", 32'(busy), 32'd4);
    chk("rd005_q_pre", 32'(qf), 32'h0);

    // byte-lane writes
    req(0, 1, 10'h010, 16'h1234, 2'b11, busy, qf, es, ps);
    req(0, 1, 10'h010, 16'hAB00, 2'b10, busy, qf, es, ps);
    req(1, 0, 10'h010, 16'h0, 2'b00, busy, qf, es, ps);
    chk("lane_q", 32'(q), 32'hAB34);

    // rd and wr together: only the read happens
    req(0, 1, 10'h020, 16'h0F0F, 2'b11, busy, qf, es, ps);
    req(1, 1, 10'h020, 16'hFFFF, 2'b11, busy, qf, es, ps);
    chk("rdwr_q", 32'(q), 32'h0F0F);
    req(1, 0, 10'h020, 16'h0, 2'b00, busy, qf, es, ps);
    chk("rdwr_q2", 32'(q), 32'h0F0F);

    // out of range write/read, memory untouched
    req(0, 1, 10'h000, 16'h1111, 2'b11, busy, qf, es, ps);
    req(0, 1, 10'h100, 16'h2222, 2'b11, busy, qf, es, ps);
    req(0, 1, 10'h300, 16'h5555, 2'b11, busy, qf, es, ps);
    chk("oor_wr_err", 32'(es), 32'd1);
    req(1, 0, 10'h300, 16'h0, 2'b00, busy, qf, es, ps);
    chk("oor_rd_err", 32'(es), 32'd1);
    chk("oor_rd_q", 32'(q), 32'h0);
    req(1, 0, 10'h000, 16'h0, 2'b00, busy, qf, es, ps);
    chk("oor_alias0", 32'(q), 32'h1111);
    req(1, 0, 10'h100, 16'h0, 2'b00, busy, qf, es, ps);
    chk("oor_alias100", 32'(q), 32'h2222);
    chk("inr_err", 32'(es), 32'd0);

    // reset during the second DELAY cycle
    wait_idle();
    rd = 1; addr = 10'h010;
    @(negedge clock); rd = 0;
    @(negedge clock);
    @(negedge clock); reset = 0;
    @(negedge clock);
    chk("rstd_mwait", 32'(mwait), 32'd0);
    chk("rstd_q", 32'(q), 32'h0);
    chk("rstd_done", 32'(done), 32'd0);
    reset = 1;

    // reset coinciding with a write in ACCESS drops the write
    wait_idle();
    wr = 1; addr = 10'h010; d = 16'hFFFF; be = 2'b11;
    @(negedge clock); wr = 0; reset = 0;
    @(negedge clock); reset = 1;
    req(1, 0, 10'h010, 16'h0, 2'b00, busy, qf, es, ps);
    chk("rstw_q", 32'(q), 32'hAB34);

`ifdef BRAM_PARITY_EN
    req(0, 1, 10'h001, 16'h00FF, 2'b11, busy, qf, es, ps);
    dut.m[1][0] = ~dut.m[1][0];
    mm[1][0] = ~mm[1][0];
    req(1, 0, 10'h001, 16'h0, 2'b00, busy, qf, es, ps);
    chk("par_perr", 32'(ps), 32'd1);
    chk("par_q", 32'(q), 32'h00FE);
    req(1, 0, 10'h010, 16'h0, 2'b00, busy, qf, es, ps);
    chk("par_clean", 32'(ps), 32'd0);
`endif

    // randomized traffic, requests held or dropped arbitrarily
    for (int c = 0; c < 4000; c++) begin
      rd    = ($urandom_range(0, 3) == 0);
      wr    = ($urandom_range(0, 2) == 0);
      addr  = $urandom_range(0, 1) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(760, 775));
      d     = 16'($urandom);
      be    = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 299) != 0);
      @(negedge clock);
    end
    rd = 0; wr = 0; reset = 1;
    wait_idle();
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
